scoreboard_issue_ctrl: RTL and testbench

Issue controller placed between the instruction-decode stage and the execute stage of the 4-stage pipelined core. It keeps a per-register scoreboard of in-flight writes and holds decode (dec_ready low) on read-after-write hazards until the producing write has retired through writeback. It also provides a drain/serialize sequence and a saturating stall counter for performance debug.

---
 rtl/scoreboard_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_scoreboard_issue_ctrl.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_issue_ctrl.sv
// Issue controller between decode and execute: per-register scoreboard,
// RAW stall, drain/serialize sequence and saturating stall counter.
module scoreboard_issue_ctrl #(
  parameter int NREG       = 8,
  parameter int RW         = 3,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [RW-1:0]    dec_rd,
  input  logic [RW-1:0]    dec_rs1,
  input  logic [RW-1:0]    dec_rs2,
  input  logic             dec_uses_rs2,
  input  logic             dec_writes_rd,
  input  logic             drain_req,
  output logic             dec_ready,
  output logic             issue,
  output logic [NREG-1:0]  busy_mask,
  output logic             drained,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PW = $clog2(PIPE_DEPTH + 1);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         pend_q [NREG];
  logic [PW-1:0]         pend_d [NREG];
  logic [PIPE_DEPTH-1:0] vld_q, vld_d;
  logic [RW-1:0]         rd_q [PIPE_DEPTH];
  logic [RW-1:0]         rd_d [PIPE_DEPTH];
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  drained_q, drained_d;
  logic [CNT_W-1:0]      stall_q, stall_d;

  logic          hazard;
  logic          push;
  logic          ret_v;
  logic [RW-1:0] ret_rd;

  // hazard looks only at registered busy bits
  assign hazard = busy_q[dec_rs1] |
                  (dec_uses_rs2 & busy_q[dec_rs2]);

  assign dec_ready = (state_q == S_RUN) & ~hazard;
  assign issue     = dec_valid & dec_ready;
  assign push      = issue & dec_writes_rd;
  assign ret_v     = vld_q[PIPE_DEPTH-1];
  assign ret_rd    = rd_q[PIPE_DEPTH-1];

  assign busy_mask = busy_q;
  assign drained   = drained_q;
  assign stall_cnt = stall_q;

  always_comb begin
    for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
      vld_d[i] = vld_q[i-1];
      rd_d[i]  = rd_q[i-1];
    end
    vld_d[0] = push;
    rd_d[0]  = dec_rd;
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      pend_d[i] = pend_q[i];
      if (push && dec_rd == RW'(i))
        pend_d[i] = pend_d[i] + PW'(1);
      if (ret_v && ret_rd == RW'(i))
        pend_d[i] = pend_d[i] - PW'(1);
      busy_d[i] = (pend_d[i] != '0);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == S_RUN:
        if (drain_req) state_d = S_DRAIN;
      state_q == S_DRAIN:
        if (busy_q == '0 && vld_q == '0)
          state_d = S_DONE;
      state_q == S_DONE:
        state_d = S_RUN;
      default:
        state_d = S_RUN;
    endcase
    drained_d = (state_d == S_DONE);
  end

  always_comb begin
    stall_d = stall_q;
    if (dec_valid && !dec_ready && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RUN;
      vld_q     <= '0;
      busy_q    <= '0;
      drained_q <= 1'b0;
      stall_q   <= '0;
      for (int i = 0; i < NREG; i++)
        pend_q[i] <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++)
        rd_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      drained_q <= drained_d;
      stall_q   <= stall_d;
      for (int i = 0; i < NREG; i++)
        pend_q[i] <= pend_d[i];
      for (int i = 0; i < PIPE_DEPTH; i++)
        rd_q[i] <= rd_d[i];
    end
  end

endmodule

// File: tb/tb_scoreboard_issue_ctrl.sv
// Bench for scoreboard_issue_ctrl: directed scenarios plus a
// randomized run against an in-flight-write list model.
module tb_scoreboard_issue_ctrl;

  localparam int NREG = 8;
  localparam int RW   = 3;
  localparam int PD   = 3;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          dec_valid = 1'b0;
  logic [RW-1:0] dec_rd = '0;
  logic [RW-1:0] dec_rs1 = '0;
  logic [RW-1:0] dec_rs2 = '0;
  logic          dec_uses_rs2 = 1'b0;
  logic          dec_writes_rd = 1'b0;
  logic          drain_req = 1'b0;

  logic            dec_ready, issue, drained;
  logic [NREG-1:0] busy_mask;
  logic [CW-1:0]   stall_cnt;

  logic            s_ready, s_issue, s_drained;
  logic [NREG-1:0] s_busy;
  logic [3:0]      s_stall;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int rd;
    int c;
  } wr_t;

  wr_t inflight[$];
  int  cyc;

  always #5 clk = ~clk;

  scoreboard_issue_ctrl #(
    .NREG(NREG), .RW(RW), .PIPE_DEPTH(PD), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_rd(dec_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_uses_rs2(dec_uses_rs2),
    .dec_writes_rd(dec_writes_rd),
    .drain_req(drain_req),
    .dec_ready(dec_ready), .issue(issue),
    .busy_mask(busy_mask), .drained(drained),
    .stall_cnt(stall_cnt)
  );

  scoreboard_issue_ctrl #(
    .NREG(NREG), .RW(RW), .PIPE_DEPTH(PD), .CNT_W(4)
  ) s_dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_rd(dec_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_uses_rs2(dec_uses_rs2),
    .dec_writes_rd(dec_writes_rd),
    .drain_req(drain_req),
    .dec_ready(s_ready), .issue(s_issue),
    .busy_mask(s_busy), .drained(s_drained),
    .stall_cnt(s_stall)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int rd,
                       input int rs1, input int rs2,
                       input logic u2, input logic w);
    dec_valid     = v;
    dec_rd        = 3'(rd);
    dec_rs1       = 3'(rs1);
    dec_rs2       = 3'(rs2);
    dec_uses_rs2  = u2;
    dec_writes_rd = w;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drain_req = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    next();
    reset = 1'b1;
  endtask

  // register busy in cycle k if written at c with c < k <= c+PD
  function automatic logic [NREG-1:0] m_busy();
    logic [NREG-1:0] b;
    b = '0;
    foreach (inflight[i])
      if (inflight[i].c < cyc && cyc <= inflight[i].c + PD)
        b[inflight[i].rd] = 1'b1;
    return b;
  endfunction

  task automatic test_reset();
    drive(1, 2, 1, 0, 0, 1);
    #12;
    tests++;
    if (dec_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got=%b exp=1", dec_ready);
    end
    tests++;
    if (busy_mask !== 8'h00) begin
      fails++;
      $display("FAIL reset_busy got=%h exp=00", busy_mask);
    end
    tests++;
    if (stall_cnt !== 16'd0 || s_stall !== 4'd0) begin
      fails++;
      $display("FAIL reset_stall got=%0d/%0d exp=0",
               stall_cnt, s_stall);
    end
    tests++;
    if (drained !== 1'b0) begin
      fails++;
      $display("FAIL reset_drained got=%b exp=0", drained);
    end
    drive(0, 0, 0, 0, 0, 0);
    next();
    reset = 1'b1;
  endtask

  task automatic test_independent();
    do_reset();
    drive(1, 1, 2, 3, 1, 1);
    #3;
    tests++;
    if (issue !== 1'b1) begin
      fails++;
      $display("FAIL indep_issue0 got=%b exp=1", issue);
    end
    next();
    drive(1, 4, 5, 6, 1, 1);
    #3;
    tests++;
    if (issue !== 1'b1 || busy_mask !== 8'h02) begin
      fails++;
      $display("FAIL indep_t1 issue=%b busy=%h exp 1/02",
               issue, busy_mask);
    end
    next();
    drive(0, 0, 0, 0, 0, 0);
    #3;
    tests++;
    if (busy_mask !== 8'h12) begin
      fails++;
      $display("FAIL indep_t2 busy got=%h exp=12", busy_mask);
    end
    next();
    next();
    #3;
    tests++;
    if (busy_mask !== 8'h10) begin
      fails++;
      $display("FAIL indep_t4 busy got=%h exp=10", busy_mask);
    end
    next();
    #3;
    tests++;
    if (busy_mask !== 8'h00 || stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL indep_t5 busy=%h stall=%0d exp 00/0",
               busy_mask, stall_cnt);
    end
    next();
  endtask

  task automatic test_raw();
    do_reset();
    drive(1, 1, 0, 0, 0, 1);
    next();
    drive(1, 2, 1, 0, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      #3;
      tests++;
      if (dec_ready !== 1'b0) begin
        fails++;
        $display("FAIL raw_stall_t%0d got=%b exp=0",
                 k, dec_ready);
      end
      next();
    end
    #3;
    tests++;
    if (issue !== 1'b1) begin
      fails++;
      $display("FAIL raw_issue_t4 got=%b exp=1", issue);
    end
    next();
    drive(0, 0, 0, 0, 0, 0);
    #3;
    tests++;
    if (stall_cnt !== 16'd3) begin
      fails++;
      $display("FAIL raw_stall_cnt got=%0d exp=3", stall_cnt);
    end
    repeat (4) next();
  endtask

  task automatic test_repeat();
    do_reset();
    drive(1, 2, 0, 0, 0, 1);
    next();
    drive(1, 2, 0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      #3;
      tests++;
      if (busy_mask[2] !== 1'b1) begin
        fails++;
        $display("FAIL rep_busy_t%0d got=%b exp=1",
                 k, busy_mask[2]);
      end
      next();
      drive(1, 5, 2, 0, 0, 0);
    end
    #3;
    tests++;
    if (busy_mask[2] !== 1'b0 || issue !== 1'b1) begin
      fails++;
      $display("FAIL rep_t5 busy2=%b issue=%b exp 0/1",
               busy_mask[2], issue);
    end
    next();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_drain();
    do_reset();
    drive(1, 1, 0, 0, 0, 1);
    next();
    drive(1, 3, 0, 0, 0, 1);
    drain_req = 1'b1;
    #3;
    tests++;
    if (issue !== 1'b1) begin
      fails++;
      $display("FAIL drain_issue_same got=%b exp=1", issue);
    end
    next();
    drain_req = 1'b0;
    drive(1, 5, 0, 0, 0, 1);
    for (int k = 2; k <= 5; k++) begin
      #3;
      tests++;
      if (dec_ready !== 1'b0 || drained !== 1'b0) begin
        fails++;
        $display("FAIL drain_wait_t%0d rdy=%b drn=%b exp 0/0",
                 k, dec_ready, drained);
      end
      next();
    end
    #3;
    tests++;
    if (drained !== 1'b1 || dec_ready !== 1'b0) begin
      fails++;
      $display("FAIL drain_done drn=%b rdy=%b exp 1/0",
               drained, dec_ready);
    end
    next();
    #3;
    tests++;
    if (drained !== 1'b0 || issue !== 1'b1) begin
      fails++;
      $display("FAIL drain_resume drn=%b iss=%b exp 0/1",
               drained, issue);
    end
    next();
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) next();
    drain_req = 1'b1;
    next();
    #3;
    tests++;
    if (drained !== 1'b0 || dec_ready !== 1'b0) begin
      fails++;
      $display("FAIL idle_drain_u1 drn=%b rdy=%b exp 0/0",
               drained, dec_ready);
    end
    next();
    drain_req = 1'b0;
    #3;
    tests++;
    if (drained !== 1'b1) begin
      fails++;
      $display("FAIL idle_drain_u2 got=%b exp=1", drained);
    end
    next();
    #3;
    tests++;
    if (drained !== 1'b0 || dec_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_drain_u3 drn=%b rdy=%b exp 0/1",
               drained, dec_ready);
    end
    next();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 1, 0, 0, 0, 1);
    next();
    drive(1, 2, 1, 0, 0, 0);
    repeat (3) next();
    drive(1, 1, 1, 0, 0, 1);
    next();
    drive(1, 2, 1, 0, 0, 0);
    repeat (3) next();
    drive(1, 3, 1, 0, 0, 1);
    next();
    drive(1, 3, 0, 0, 0, 1);
    next();
    drive(1, 4, 3, 0, 0, 0);
    next();
    #3;
    tests++;
    if (stall_cnt !== 16'd7 || busy_mask !== 8'h08 ||
        dec_ready !== 1'b0) begin
      fails++;
      $display("FAIL arst_pre stall=%0d busy=%h rdy=%b exp 7/08/0",
               stall_cnt, busy_mask, dec_ready);
    end
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if (busy_mask !== 8'h00 || stall_cnt !== 16'd0 ||
        dec_ready !== 1'b1) begin
      fails++;
      $display("FAIL arst_async busy=%h stall=%0d rdy=%b exp 00/0/1",
               busy_mask, stall_cnt, dec_ready);
    end
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if (issue !== 1'b1) begin
      fails++;
      $display("FAIL arst_issue got=%b exp=1", issue);
    end
    next();
    drive(0, 0, 0, 0, 0, 0);
    #3;
    tests++;
    if (busy_mask !== 8'h00 || stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL arst_post busy=%h stall=%0d exp 00/0",
               busy_mask, stall_cnt);
    end
    next();
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 1, 1, 0, 0, 1);
    for (int k = 0; k < 28; k++) begin
      #3;
      tests++;
      if (dec_ready !== (k % 4 == 0)) begin
        fails++;
        $display("FAIL sat_ready_k%0d got=%b exp=%b",
                 k, dec_ready, (k % 4 == 0));
      end
      next();
    end
    drive(0, 0, 0, 0, 0, 0);
    #3;
    tests++;
    if (stall_cnt !== 16'd21) begin
      fails++;
      $display("FAIL sat_wide got=%0d exp=21", stall_cnt);
    end
    tests++;
    if (s_stall !== 4'd15) begin
      fails++;
      $display("FAIL sat_narrow got=%0d exp=15", s_stall);
    end
    repeat (4) next();
  endtask

  task automatic test_random();
    logic            hold;
    int              mode;
    int              est;
    logic [NREG-1:0] mb;
    logic            er, ei;
    do_reset();
    inflight.delete();
    cyc  = 0;
    mode = 0;
    est  = 0;
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold)
        drive(($urandom_range(0, 9) < 7),
              $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      drain_req = ($urandom_range(0, 24) == 0);
      #3;
      mb = m_busy();
      er = (mode == 0) &&
           !(mb[dec_rs1] || (dec_uses_rs2 && mb[dec_rs2]));
      ei = dec_valid && er;
      tests++;
      if (dec_ready !== er || issue !== ei) begin
        fails++;
        $display("FAIL rnd_ready n=%0d rdy=%b iss=%b exp %b/%b",
                 n, dec_ready, issue, er, ei);
      end
      tests++;
      if (busy_mask !== mb) begin
        fails++;
        $display("FAIL rnd_busy n=%0d got=%h exp=%h",
                 n, busy_mask, mb);
      end
      tests++;
      if (drained !== (mode == 2)) begin
        fails++;
        $display("FAIL rnd_drained n=%0d got=%b exp=%b",
                 n, drained, (mode == 2));
      end
      tests++;
      if (stall_cnt !== 16'(est)) begin
        fails++;
        $display("FAIL rnd_stall n=%0d got=%0d exp=%0d",
                 n, stall_cnt, est);
      end
      next();
      if (ei && dec_writes_rd)
        inflight.push_back('{rd: int'(dec_rd), c: cyc});
      if (dec_valid && !er && est != 65535)
        est++;
      if (mode == 0 && drain_req)
        mode = 1;
      else if (mode == 1 && mb == '0)
        mode = 2;
      else if (mode == 2)
        mode = 0;
      cyc++;
      while (inflight.size() > 0 && inflight[0].c + PD < cyc)
        void'(inflight.pop_front());
      hold = dec_valid && !er;
    end
    drain_req = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_repeat();
    test_drain();
    test_async_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
